// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - dual-port word memory answering instruction fetches and data loads/stores
//
// Purpose: on-chip memory / bring-up target for the split instruction/data
// memory interface. One 2^ADDR_WIDTH x 32 array, two independent request
// FSMs (IDLE/BUSY/RESP) with fixed per-port response latency.
//
// Ports:
//   clk, rst                    clock, async active-low reset
//   instr_read                  fetch request (held until response)
//   instr_mem_address[31:0]     fetch byte address
//   instr_mem_resp              one-cycle fetch response pulse
//   instr_mem_rdata[31:0]       fetched word, held until next fetch completes
//   data_read, data_write       load / store request (both high = store)
//   data_mbe[3:0]               store byte-lane enables
//   data_mem_address[31:0]      load/store byte address
//   data_mem_wdata[31:0]        lane-aligned store data
//   data_mem_resp               one-cycle load/store response pulse
//   data_mem_rdata[31:0]        loaded word, held until next load completes

module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int I_LATENCY  = 1,
  parameter int D_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] I_LOAD = 4'(I_LATENCY - 1);
  localparam logic [3:0] D_LOAD = 4'(D_LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t                i_state;
  logic [3:0]            i_cnt;
  logic [ADDR_WIDTH-1:0] i_idx;

  state_t                d_state;
  logic [3:0]            d_cnt;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic                  d_wr;
  logic [3:0]            d_mbe;
  logic [31:0]           d_wdata;

  logic [ADDR_WIDTH-1:0] i_addr_idx;
  logic [ADDR_WIDTH-1:0] d_addr_idx;

  // Byte offset and bits above the array size are intentionally dropped (aliasing).
  assign i_addr_idx = instr_mem_address[ADDR_WIDTH+1:2];
  assign d_addr_idx = data_mem_address[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_mem_address[31:ADDR_WIDTH+2], instr_mem_address[1:0],
                              data_mem_address[31:ADDR_WIDTH+2], data_mem_address[1:0]};

  // Instruction port: the read happens on the edge entering RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_state         <= IDLE;
      i_cnt           <= 4'd0;
      i_idx           <= '0;
      instr_mem_resp  <= 1'b0;
      instr_mem_rdata <= 32'd0;
    end else begin
      instr_mem_resp <= 1'b0;
      case (i_state)
        IDLE: begin
          if (instr_read) begin
            i_idx <= i_addr_idx;
            if (I_LATENCY == 1) begin
              i_state         <= RESP;
              instr_mem_resp  <= 1'b1;
              instr_mem_rdata <= mem[i_addr_idx];
            end else begin
              i_cnt   <= I_LOAD;
              i_state <= BUSY;
            end
          end
        end
        BUSY: begin
          i_cnt <= i_cnt - 4'd1;
          if (i_cnt == 4'd1) begin
            i_state         <= RESP;
            instr_mem_resp  <= 1'b1;
            instr_mem_rdata <= mem[i_idx];
          end
        end
        default: i_state <= IDLE;
      endcase
    end
  end

  // Data port: loads read on the edge entering RESP; stores commit on the
  // edge leaving RESP (see array write below) and leave rdata untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state        <= IDLE;
      d_cnt          <= 4'd0;
      d_idx          <= '0;
      d_wr           <= 1'b0;
      d_mbe          <= 4'd0;
      d_wdata        <= 32'd0;
      data_mem_resp  <= 1'b0;
      data_mem_rdata <= 32'd0;
    end else begin
      data_mem_resp <= 1'b0;
      case (d_state)
        IDLE: begin
          if (data_read || data_write) begin
            d_idx   <= d_addr_idx;
            d_wr    <= data_write;
            d_mbe   <= data_mbe;
            d_wdata <= data_mem_wdata;
            if (D_LATENCY == 1) begin
              d_state       <= RESP;
              data_mem_resp <= 1'b1;
              if (!data_write) data_mem_rdata <= mem[d_addr_idx];
            end else begin
              d_cnt   <= D_LOAD;
              d_state <= BUSY;
            end
          end
        end
        BUSY: begin
          d_cnt <= d_cnt - 4'd1;
          if (d_cnt == 4'd1) begin
            d_state       <= RESP;
            data_mem_resp <= 1'b1;
            if (!d_wr) data_mem_rdata <= mem[d_idx];
          end
        end
        default: d_state <= IDLE;
      endcase
    end
  end

  // Array is never reset. A reset during a store returns d_state to IDLE
  // before the commit edge, so the store is dropped. Reads on the commit
  // edge see the old word because all updates are non-blocking.
  always_ff @(posedge clk) begin
    if (d_state == RESP && d_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (d_mbe[i]) mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_read = 1'b0;
  logic [31:0] instr_mem_address = 32'd0;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [3:0]  data_mbe = 4'd0;
  logic [31:0] data_mem_address = 32'd0;
  logic [31:0] data_mem_wdata = 32'd0;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.ADDR_WIDTH(10), .I_LATENCY(1), .D_LATENCY(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_mbe          (data_mbe),
    .data_mem_address  (data_mem_address),
    .data_mem_wdata    (data_mem_wdata),
    .data_mem_resp     (data_mem_resp),
    .data_mem_rdata    (data_mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data transaction; returns data_mem_rdata as seen on the resp cycle.
  task automatic d_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mbe,
                        output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = 32'd0;
    data_read = rd;
    data_write = wr;
    data_mem_address = addr;
    data_mem_wdata = wdata;
    data_mbe = mbe;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_mem_resp) begin
        got = 1'b1;
        rdata = data_mem_rdata;
        break;
      end
    end
    data_read = 1'b0;
    data_write = 1'b0;
    check("d_resp_seen", {31'd0, got}, 32'd1);
    tick();
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] rdata);
    logic got;
    got = 1'b0;
    rdata = 32'd0;
    instr_read = 1'b1;
    instr_mem_address = addr;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_mem_resp) begin
        got = 1'b1;
        rdata = instr_mem_rdata;
        break;
      end
    end
    instr_read = 1'b0;
    check("i_resp_seen", {31'd0, got}, 32'd1);
    tick();
  endtask

  logic [31:0] rd;

  initial begin
    // Reset held with both requests active.
    instr_read = 1'b1;
    data_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_i_resp", instr_mem_resp, 32'd0);
      check("rst_d_resp", data_mem_resp, 32'd0);
      check("rst_i_rdata", instr_mem_rdata, 32'd0);
      check("rst_d_rdata", data_mem_rdata, 32'd0);
    end
    rst = 1'b1;
    tick();
    check("post_rst_i_resp", instr_mem_resp, 32'd1);
    check("post_rst_d_busy", data_mem_resp, 32'd0);
    instr_read = 1'b0;
    tick();
    check("post_rst_d_resp", data_mem_resp, 32'd1);
    check("post_rst_i_idle", instr_mem_resp, 32'd0);
    data_read = 1'b0;
    tick();
    tick();

    // Preload known words.
    d_xfer(1'b0, 1'b1, 32'h0,  32'h0000_0013, 4'b1111, rd);
    d_xfer(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b1111, rd);
    d_xfer(1'b0, 1'b1, 32'h80, 32'h0000_0000, 4'b1111, rd);
    d_xfer(1'b0, 1'b1, 32'h8,  32'h0000_0077, 4'b1111, rd);

    // Held-high fetch streams: resp in cycles 1,3,5.
    instr_read = 1'b1;
    instr_mem_address = 32'h0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("stream_resp_c%0d", c), instr_mem_resp, (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c % 2 == 1) check($sformatf("stream_rdata_c%0d", c), instr_mem_rdata, 32'h0000_0013);
    end
    instr_read = 1'b0;
    tick();
    tick();

    // Byte-enable store, latency 2.
    data_write = 1'b1;
    data_mem_address = 32'h40;
    data_mem_wdata = 32'hAABB_CCDD;
    data_mbe = 4'b0101;
    tick();
    check("be_store_c1", data_mem_resp, 32'd0);
    tick();
    check("be_store_c2", data_mem_resp, 32'd1);
    data_write = 1'b0;
    tick();
    d_xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, rd);
    check("be_load", rd, 32'h11BB_33DD);

    // Collision: fetch read edge equals store commit edge.
    data_write = 1'b1;
    data_mem_address = 32'h80;
    data_mem_wdata = 32'hDEAD_BEEF;
    data_mbe = 4'b1111;
    tick();
    tick();
    check("coll_store_resp", data_mem_resp, 32'd1);
    data_write = 1'b0;
    instr_read = 1'b1;
    instr_mem_address = 32'h80;
    tick();
    check("coll_fetch_resp", instr_mem_resp, 32'd1);
    check("coll_fetch_old", instr_mem_rdata, 32'h0);
    instr_read = 1'b0;
    tick();
    tick();
    fetch(32'h80, rd);
    check("coll_fetch_new", rd, 32'hDEAD_BEEF);

    // Aliasing modulo 2^12 bytes.
    d_xfer(1'b0, 1'b1, 32'h1004, 32'h0000_0005, 4'b1111, rd);
    d_xfer(1'b1, 1'b0, 32'h0004, 32'h0, 4'b0000, rd);
    check("alias_load", rd, 32'h0000_0005);

    // Read+write together acts as a store; rdata keeps prior load value.
    d_xfer(1'b1, 1'b0, 32'h40, 32'h0, 4'b0000, rd);
    check("rw_pre_load", rd, 32'h11BB_33DD);
    d_xfer(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'b1111, rd);
    check("rw_rdata_held", rd, 32'h11BB_33DD);
    d_xfer(1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, rd);
    check("rw_written", rd, 32'hCAFE_F00D);

    // Zero byte-enable store writes nothing but still responds.
    d_xfer(1'b0, 1'b1, 32'h100, 32'h1234_5678, 4'b0000, rd);
    d_xfer(1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, rd);
    check("mbe0_unchanged", rd, 32'hCAFE_F00D);

    // Reset during BUSY of a store drops it.
    data_write = 1'b1;
    data_mem_address = 32'h8;
    data_mem_wdata = 32'h0000_0001;
    data_mbe = 4'b1111;
    tick();
    check("mid_rst_busy", data_mem_resp, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_rdata", data_mem_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_resp", data_mem_resp, 32'd0);
    end
    data_write = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_mid_rst_no_resp", data_mem_resp, 32'd0);
    end
    d_xfer(1'b1, 1'b0, 32'h8, 32'h0, 4'b0000, rd);
    check("mid_rst_old_value", rd, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
